// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequencer for a 32-point, 5-stage pipelined FFT (frame/fill/flush control, butterfly and twiddle decode).
// Define FFT_SEQ_CTRL_BITREV_EN to report out_idx_o as natural-order bin number instead of arrival order.
module fft_seq_ctrl #(
  parameter int STG_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        en_o,
  output logic        zero_o,
  output logic [4:0]  bf_sel_o,
  output logic [15:0] tw_addr_o,
  output logic        valid_o,
  output logic [4:0]  out_idx_o,
  output logic        busy_o
);
  localparam logic [5:0] LAT = 6'(31 + 5 * STG_LAT);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [4:0] tc_q, tc_d, oc_q, oc_d;
  logic [5:0] fc_q, fc_d, fl_q, fl_d;
  always_comb begin
    state_d = state_q;
    en_o    = valid_i;
    zero_o  = 1'b0;
    case (state_q)
      IDLE:    if (valid_i) state_d = RUN;
      RUN:     if (!valid_i && tc_q == 5'd0) state_d = FLUSH;
      FLUSH: begin
        en_o   = 1'b1;
        zero_o = 1'b1;
        if (fl_q == LAT - 6'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_o = en_o && fc_q == LAT;
    tc_d    = en_o ? tc_q + 5'd1 : tc_q;
    fc_d    = (en_o && fc_q != LAT) ? fc_q + 6'd1 : fc_q;
    oc_d    = valid_o ? oc_q + 5'd1 : oc_q;
    fl_d    = state_q == FLUSH ? fl_q + 6'd1 : 6'd0;
    if (state_q == FLUSH && state_d == IDLE) begin
      tc_d = '0;
      fc_d = '0;
      oc_d = '0;
      fl_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tc_q    <= '0;
      fc_q    <= '0;
      oc_q    <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      fc_q    <= fc_d;
      oc_q    <= oc_d;
      fl_q    <= fl_d;
    end
  end
  assign busy_o  = state_q != IDLE;
  assign ready_o = state_q != FLUSH;
  // Stage decode is blanked in IDLE: nothing of a frame is in the pipe yet.
  for (genvar k = 1; k <= 5; k++) begin : g_stg
    localparam logic [4:0] OFS = 5'(32 - (64 >> k) + (k - 1) * STG_LAT);
    logic [4:0] p;
    assign p = tc_q - OFS;
    assign bf_sel_o[k-1] = busy_o & p[5-k];
    if (k < 5) begin : g_tw
      assign tw_addr_o[4*k-1 -: 4] = busy_o ? 4'((p & 5'((32 >> k) - 1)) << (k - 1)) : 4'd0;
    end
  end
`ifdef FFT_SEQ_CTRL_BITREV_EN
  assign out_idx_o = {<<{oc_q}};
`else
  assign out_idx_o = oc_q;
`endif
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: directed bench for fft_seq_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_fft_seq_ctrl;
  localparam int STG = 1;
  localparam int LAT = 31 + 5 * STG;
  logic clk = 1'b0, rst_n = 1'b0, vin = 1'b0;
  logic ready, en, zero, vout, busy;
  logic [4:0] bf, idx;
  logic [15:0] tw;
  int n_chk = 0, n_fail = 0;
  fft_seq_ctrl #(.STG_LAT(STG)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(vin), .ready_o(ready), .en_o(en), .zero_o(zero),
    .bf_sel_o(bf), .tw_addr_o(tw), .valid_o(vout), .out_idx_o(idx), .busy_o(busy)
  );
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < 5; i++) if (x[i]) r |= 1 << (4 - i);
    return r;
  endfunction

  function automatic int exp_idx(input int oc);
`ifdef FFT_SEQ_CTRL_BITREV_EN
    return brev(oc);
`else
    return oc;
`endif
  endfunction

  // Model: a session starts at the first accepted sample; m_n counts enabled cycles in it.
  int m_n = 0, m_fl = 0, e_bf, e_tw, p, oc;
  bit m_sess = 0, m_f, m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_n = 0;
      m_fl = 0;
      m_sess = 0;
    end
    m_f = m_fl > 0;
    m_e = m_f | vin;
    e_bf = 0;
    e_tw = 0;
    if (m_sess)
      for (int k = 1; k <= 5; k++) begin
        p = ((m_n - (32 - (64 >> k) + (k - 1) * STG)) % 32 + 32) % 32;
        if (p[5-k]) e_bf |= 1 << (k - 1);
        if (k < 5) e_tw |= (((p % (32 >> k)) << (k - 1)) % 16) << (4 * (k - 1));
      end
    oc = m_n > LAT ? (m_n - LAT) % 32 : 0;
    chk("ready", ready, !m_f);
    chk("en", en, m_e);
    chk("zero", zero, m_f);
    chk("busy", busy, m_sess);
    chk("valid", vout, m_e && m_n >= LAT);
    chk("bf_sel", bf, e_bf);
    chk("tw_addr", tw, e_tw);
    chk("out_idx", idx, exp_idx(oc));
    if (rst_n) begin
      if (m_f) begin
        m_n++;
        m_fl--;
        if (m_fl == 0) begin
          m_sess = 0;
          m_n = 0;
        end
      end else if (!m_sess) begin
        if (vin) begin
          m_sess = 1;
          m_n = 1;
        end
      end else if (vin) m_n++;
      else if (m_n % 32 == 0) m_fl = LAT;
    end
  end

  int e_cnt, first_v, nv, nz;
  int idxs[64];
  task automatic clr();
    e_cnt = 0; first_v = -1; nv = 0; nz = 0;
  endtask
  task automatic step(input logic v);
    @(posedge clk);
    #1 vin = v;
    @(negedge clk);
    #1;
    if (en) begin
      if (vout && first_v < 0) first_v = e_cnt;
      e_cnt++;
    end
    if (vout) begin
      if (nv < 64) idxs[nv] = idx;
      nv++;
    end
    if (zero) nz++;
  endtask
  task automatic drain();
    int t = 0;
    while (busy && t < 200) begin
      step(1'b0);
      t++;
    end
    chk("drain_idle", busy, 0);
  endtask

  logic [4:0] fbf;
  logic [15:0] ftw;
  initial begin
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    // single frame
    clr();
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      if (i == 16) begin
        chk("p1_bf_at16", bf[0], 1);
        chk("p1_tw_at16", tw[3:0], 0);
      end
      if (i == 20) chk("p1_tw_at20", tw[3:0], 4);
      if (i == 25) chk("p2_bf_at25", bf[1], 1);
    end
    drain();
    chk("single_flush_len", nz, 36);
    chk("single_first_valid", first_v, 36);
    chk("single_nvalid", nv, 32);
    chk("single_en_cycles", e_cnt, 68);
    // two back-to-back frames
    clr();
    for (int i = 0; i < 64; i++) step(1'b1);
    chk("b2b_no_flush", nz, 0);
    drain();
    chk("b2b_nvalid", nv, 64);
`ifdef FFT_SEQ_CTRL_BITREV_EN
    chk("b2b_idx1_lit", idxs[1], 16);
    chk("b2b_idx3_lit", idxs[3], 24);
`else
    chk("b2b_idx1_lit", idxs[1], 1);
    chk("b2b_idx3_lit", idxs[3], 3);
`endif
    for (int i = 0; i < 64; i += 31) chk("b2b_idx", idxs[i], exp_idx(i % 32));
    // mid-frame stall
    clr();
    for (int i = 0; i < 10; i++) step(1'b1);
    step(1'b0);
    fbf = bf;
    ftw = tw;
    chk("stall_en", en, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      chk("stall_en", en, 0);
      chk("stall_busy", busy, 1);
      chk("stall_bf_frozen", bf, fbf);
      chk("stall_tw_frozen", tw, ftw);
    end
    for (int i = 0; i < 22; i++) step(1'b1);
    drain();
    chk("stall_nvalid", nv, 32);
    chk("stall_first_valid", first_v, 36);
    chk("stall_flush_len", nz, 36);
    // reset during flush
    clr();
    for (int i = 0; i < 32; i++) step(1'b1);
    step(1'b0);
    for (int f = 0; f < 10; f++) begin
      step(1'b1);
      chk("flush_zero", zero, 1);
      chk("flush_ready", ready, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_en", en, 1);
    chk("rst_zero", zero, 0);
    chk("rst_bf", bf, 0);
    chk("rst_tw", tw, 0);
    chk("rst_valid", vout, 0);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    vin = 1'b0;
    repeat (2) step(1'b0);
    rst_n = 1'b1;
    clr();
    for (int i = 0; i < 32; i++) step(1'b1);
    drain();
    chk("post_rst_nvalid", nv, 32);
    chk("post_rst_first_valid", first_v, 36);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
